// File: rtl/moving_avg.sv
`default_nettype none
// ============================================================================
// Module      : moving_avg
// Description : Running mean of the last 2^LOG2_N unsigned samples, with
//               optional round-half-up on the final divide-by-shift.
// Revision    : 1.0 - initial release
// ============================================================================
module moving_avg #(
  parameter int W      = 4,
  parameter int LOG2_N = 1,
  parameter int ROUND  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_data,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic                  window_full,
  output logic [W+LOG2_N-1:0]   sum_out
);

  localparam int SW = W + LOG2_N;
  localparam int N  = 1 << LOG2_N;

  localparam logic [LOG2_N:0] c_FULL = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [SW:0]     c_HALF = (ROUND != 0) ? ({{SW{1'b0}}, 1'b1} << (LOG2_N - 1)) : '0;

  logic [W-1:0]      r_buf [N];
  logic [LOG2_N-1:0] r_wr_ptr;
  logic [LOG2_N:0]   r_fill;
  logic [SW-1:0]     r_sum;
  logic              r_out_valid;
  logic [W-1:0]      r_out_data;
  logic              r_window_full;

  logic              w_accept;
  logic [W-1:0]      w_oldest;
  logic [SW-1:0]     w_sum_n;
  logic [SW:0]       w_round;
  logic              w_unused;

  assign w_accept = in_valid & ~clear;
  assign w_oldest = r_buf[r_wr_ptr];
  assign w_sum_n  = r_sum + {{LOG2_N{1'b0}}, in_data} - {{LOG2_N{1'b0}}, w_oldest};
  assign w_round  = {1'b0, w_sum_n} + c_HALF;
  // Top bit and fractional bits are discarded; the average always fits W bits.
  assign w_unused = ^{w_round[SW], w_round[LOG2_N-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_fill        <= '0;
      r_sum         <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_window_full <= 1'b0;
    end else if (clear) begin
      r_wr_ptr      <= '0;
      r_fill        <= '0;
      r_sum         <= '0;
      r_out_valid   <= 1'b0;
      r_window_full <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_sum      <= w_sum_n;
        r_out_data <= w_round[LOG2_N +: W];
        if (r_fill != c_FULL) r_fill <= r_fill + 1'b1;
        if (r_fill >= c_FULL - 1'b1) r_window_full <= 1'b1;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign window_full = r_window_full;
  assign sum_out     = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_moving_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_moving_avg
// Description : Scoreboard bench for moving_avg (main W=8/N=4 instance plus
//               W=4/N=2 truncating and rounding instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moving_avg;

  typedef struct {
    int d;
    int s;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // main instance: W=8, LOG2_N=2, ROUND=0
  logic       m_clr = 1'b0, m_iv = 1'b0;
  logic [7:0] m_id = '0;
  logic       m_ov, m_wf;
  logic [7:0] m_od;
  logic [9:0] m_sum;

  // small instances: W=4, LOG2_N=1, ROUND=0 / ROUND=1, shared inputs
  logic       s_clr = 1'b0, s_iv = 1'b0;
  logic [3:0] s_id = '0;
  logic       a_ov, a_wf, b_ov, b_wf;
  logic [3:0] a_od, b_od;
  logic [4:0] a_sum, b_sum;

  int errors = 0;
  int checks = 0;
  exp_t q_m[$];
  exp_t q_a[$];
  exp_t q_b[$];

  moving_avg #(.W(8), .LOG2_N(2), .ROUND(0)) u_main (
    .clk(clk), .rst(rst), .clear(m_clr), .in_valid(m_iv), .in_data(m_id),
    .out_valid(m_ov), .out_data(m_od), .window_full(m_wf), .sum_out(m_sum));

  moving_avg #(.W(4), .LOG2_N(1), .ROUND(0)) u_trunc (
    .clk(clk), .rst(rst), .clear(s_clr), .in_valid(s_iv), .in_data(s_id),
    .out_valid(a_ov), .out_data(a_od), .window_full(a_wf), .sum_out(a_sum));

  moving_avg #(.W(4), .LOG2_N(1), .ROUND(1)) u_round (
    .clk(clk), .rst(rst), .clear(s_clr), .in_valid(s_iv), .in_data(s_id),
    .out_valid(b_ov), .out_data(b_od), .window_full(b_wf), .sum_out(b_sum));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitors: pop one expectation per out_valid pulse, sampled on falling edge.
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (m_ov) begin
      if (q_m.size() == 0) chk("main_unexpected_valid", 1, 0);
      else begin
        e = q_m.pop_front();
        chk("main_avg", int'(m_od), e.d);
        chk("main_sum", int'(m_sum), e.s);
      end
    end
  end

  always @(negedge clk) begin : mon_trunc
    exp_t e;
    if (a_ov) begin
      if (q_a.size() == 0) chk("trunc_unexpected_valid", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("trunc_avg", int'(a_od), e.d);
        chk("trunc_sum", int'(a_sum), e.s);
      end
    end
  end

  always @(negedge clk) begin : mon_round
    exp_t e;
    if (b_ov) begin
      if (q_b.size() == 0) chk("round_unexpected_valid", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("round_avg", int'(b_od), e.d);
        chk("round_sum", int'(b_sum), e.s);
      end
    end
  end

  task automatic send_m(input int d, input int avg, input int sum);
    @(negedge clk);
    m_iv = 1'b1;
    m_id = 8'(d);
    q_m.push_back('{avg, sum});
  endtask

  task automatic send_s(input int d, input int avg_t, input int avg_r, input int sum);
    @(negedge clk);
    s_iv = 1'b1;
    s_id = 4'(d);
    q_a.push_back('{avg_t, sum});
    q_b.push_back('{avg_r, sum});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      m_iv = 1'b0;
      s_iv = 1'b0;
      m_clr = 1'b0;
    end
  endtask

  // Directed vectors: {data, expected avg, expected sum}
  int sat_v[4][3]   = '{'{15, 3, 15}, '{15, 7, 30}, '{15, 11, 45}, '{15, 15, 60}};
  int slide_v[6][3] = '{'{4, 1, 4}, '{8, 3, 12}, '{12, 6, 24},
                        '{16, 10, 40}, '{20, 14, 56}, '{24, 18, 72}};
  // small: {data, trunc avg, round avg, sum}
  int small_v[4][4] = '{'{10, 5, 5, 10}, '{7, 8, 9, 17}, '{15, 11, 11, 22}, '{15, 15, 15, 30}};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out_data", int'(m_od), 0);
    chk("reset_sum", int'(m_sum), 0);
    chk("reset_window_full", int'(m_wf), 0);
    chk("reset_out_valid", int'(m_ov), 0);
    rst = 1'b0;
    idle(1);

    // W=4, N=2: full-width sum, truncate vs round-half-up, max output
    for (int i = 0; i < 4; i++) send_s(small_v[i][0], small_v[i][1], small_v[i][2], small_v[i][3]);
    idle(2);
    chk("small_window_full", int'(a_wf), 1);

    // Saturation with 15s on the main instance
    for (int i = 0; i < 4; i++) begin
      send_m(sat_v[i][0], sat_v[i][1], sat_v[i][2]);
      if (i == 3) chk("wf_before_fourth", int'(m_wf), 0);
    end
    idle(1);
    chk("wf_after_fourth", int'(m_wf), 1);

    // Plain clear: flush, out_data holds
    @(negedge clk);
    m_clr = 1'b1;
    idle(1);
    chk("clear_sum", int'(m_sum), 0);
    chk("clear_wf", int'(m_wf), 0);
    chk("clear_hold_out", int'(m_od), 15);

    // Sliding window with wr_ptr wrap
    for (int i = 0; i < 6; i++) send_m(slide_v[i][0], slide_v[i][1], slide_v[i][2]);
    idle(3);
    chk("gap_hold_out", int'(m_od), 18);
    chk("gap_no_valid", int'(m_ov), 0);
    send_m(28, 22, 88);
    idle(2);
    send_m(0, 18, 72);
    idle(1);

    // Clear collides with a sample: sample dropped
    @(negedge clk);
    m_clr = 1'b1;
    m_iv  = 1'b1;
    m_id  = 8'd200;
    idle(1);
    chk("collide_sum", int'(m_sum), 0);
    chk("collide_wf", int'(m_wf), 0);
    chk("collide_hold_out", int'(m_od), 18);
    send_m(40, 10, 40);
    send_m(100, 35, 140);

    // Async reset between edges while streaming
    @(negedge clk);
    m_iv = 1'b1;
    m_id = 8'd50;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_data", int'(m_od), 0);
    chk("arst_sum", int'(m_sum), 0);
    chk("arst_out_valid", int'(m_ov), 0);
    chk("arst_small_wf", int'(a_wf), 0);
    @(negedge clk);
    m_iv = 1'b0;
    rst  = 1'b0;
    send_m(8, 2, 8);
    idle(1);
    chk("restart_wf", int'(m_wf), 0);
    idle(3);

    chk("main_queue_drained", q_m.size(), 0);
    chk("trunc_queue_drained", q_a.size(), 0);
    chk("round_queue_drained", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
